prio_hold_selector: RTL and testbench

PRIO_HOLD_SELECTOR -- requirements
Module: prio_hold_selector

---
 rtl/prio_hold_selector_pkg.sv | 16 +
 rtl/prio_hold_selector_if.sv | 21 ++
 rtl/prio_hold_selector_enc.sv | 25 ++
 rtl/prio_hold_selector.sv | 111 +++++++++++
 tb/tb_prio_hold_selector.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/prio_hold_selector_pkg.sv
// Shared definitions for the priority hold selector family: FSM state codes
// and default sizing parameters.
package prio_hold_selector_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRACK    = 2'd1,
    HOLDING  = 2'd2,
    OVERRIDE = 2'd3
  } state_e;

  localparam int DEF_N    = 16;
  localparam int DEF_W    = 2;
  localparam int DEF_HOLD = 8;

endpackage

// File: rtl/prio_hold_selector_if.sv
// Channel bus between the selector and its environment.
// "int" is a reserved word, so the packed per-channel command bus is named cmd.
interface prio_hold_selector_if
  import prio_hold_selector_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
);

  logic                   m;
  logic [N*W-1:0]         cmd;
  logic [N-1:0]           s;
  logic [W-1:0]           y;
  logic [$clog2(N)-1:0]   sel;
  logic [1:0]             state;
  logic                   holding;

  modport master (output m, cmd, s, input y, sel, state, holding);
  modport slave  (input m, cmd, s, output y, sel, state, holding);

endinterface

// File: rtl/prio_hold_selector_enc.sv
// Generic highest-index-wins priority encoder; idx is 0 when no bit is set.
module prio_enc_n #(
  parameter int N = 16
) (
  input  logic [N-1:0]         s,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  // Later (higher) set bits overwrite earlier ones, so the top set bit wins.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (s[i]) begin
        idx = IW'(i);
      end else begin
        idx = idx;
      end
    end
    any = |s;
  end

endmodule

// File: rtl/prio_hold_selector.sv
// Priority channel selector: tracks the highest active sensor, keeps the last
// selection for HOLD cycles after all sensors drop, and honours a master override.
module prio_hold_selector
  import prio_hold_selector_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int W    = DEF_W,
  parameter int HOLD = DEF_HOLD
) (
  input logic                  clk,
  input logic                  rst,
  prio_hold_selector_if.slave  bus
);

  localparam int IW = $clog2(N);
  // A zero-width counter is illegal, so HOLD=0 still gets one (unused) bit.
  localparam int CW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = (HOLD > 0) ? CW'(HOLD - 1) : '0;

  state_e          state_r;
  logic [IW-1:0]   sel_r;
  logic [CW-1:0]   cnt_r;
  logic            holding_r;
  logic [IW-1:0]   win_s;
  logic            any_s;
  logic [W-1:0]    y_s;

  prio_enc_n #(.N(N)) u_enc (
    .s   (bus.s),
    .idx (win_s),
    .any (any_s)
  );

  // Selection FSM; override beats every other transition on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      sel_r     <= '0;
      cnt_r     <= '0;
      holding_r <= 1'b0;
    end else if (bus.m) begin
      state_r   <= OVERRIDE;
      sel_r     <= '0;
      cnt_r     <= '0;
      holding_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE, OVERRIDE: begin
          holding_r <= 1'b0;
          if (any_s) begin
            state_r <= TRACK;
            sel_r   <= win_s;
          end else begin
            state_r <= IDLE;
            sel_r   <= '0;
          end
        end
        TRACK: begin
          if (any_s) begin
            sel_r     <= win_s;
            holding_r <= 1'b0;
          end else if (HOLD == 0) begin
            state_r   <= IDLE;
            sel_r     <= '0;
            holding_r <= 1'b0;
          end else begin
            state_r   <= HOLDING;
            cnt_r     <= HOLD_LOAD;
            holding_r <= 1'b1;
          end
        end
        HOLDING: begin
          // A returning sensor wins even on the cycle the count expires.
          if (any_s) begin
            state_r   <= TRACK;
            sel_r     <= win_s;
            holding_r <= 1'b0;
          end else if (cnt_r == '0) begin
            state_r   <= IDLE;
            sel_r     <= '0;
            holding_r <= 1'b0;
          end else begin
            cnt_r     <= cnt_r - CW'(1);
            holding_r <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          sel_r     <= '0;
          cnt_r     <= '0;
          holding_r <= 1'b0;
        end
      endcase
    end
  end

  // Live command mux: follows cmd combinationally, steered by the registered sel.
  always_comb begin
    if (state_r == OVERRIDE) begin
      y_s = bus.cmd[W-1:0];
    end else begin
      y_s = bus.cmd[W*int'(sel_r) +: W];
    end
  end

  assign bus.y       = y_s;
  assign bus.sel     = sel_r;
  assign bus.state   = state_r;
  assign bus.holding = holding_r;

endmodule

// File: tb/tb_prio_hold_selector.sv
// Directed bench for prio_hold_selector (N=16, W=2, HOLD=4) with a history-based
// reference model checked every cycle plus literal scenario expectations.
module tb_prio_hold_selector;

  localparam int N    = 16;
  localparam int W    = 2;
  localparam int HOLD = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  bit   run_cmp;

  prio_hold_selector_if #(.N(N), .W(W)) bus ();

  prio_hold_selector #(.N(N), .W(W), .HOLD(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: remembers the last winner and how many quiet edges followed it.
  bit tracked;
  bit ov;
  int last;
  int quiet;

  function automatic int highest(input logic [N-1:0] v);
    int h;
    h = -1;
    for (int i = 0; i < N; i++) if (v[i]) h = i;
    return h;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tracked <= 1'b0;
      ov      <= 1'b0;
      last    <= 0;
      quiet   <= 0;
    end else if (bus.m) begin
      ov      <= 1'b1;
      tracked <= 1'b0;
    end else if (bus.s != '0) begin
      ov      <= 1'b0;
      tracked <= 1'b1;
      last    <= highest(bus.s);
      quiet   <= 0;
    end else begin
      ov <= 1'b0;
      if (tracked) begin
        if (quiet >= HOLD) tracked <= 1'b0;
        quiet <= quiet + 1;
      end
    end
  end

  function automatic int exp_state();
    if (ov) return 3;
    if (!tracked) return 0;
    if (quiet == 0) return 1;
    return 2;
  endfunction

  function automatic int exp_sel();
    if (!ov && tracked) return last;
    return 0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  logic [N*W-1:0] cmdv;
  int             es;

  always @(negedge clk) begin
    if (run_cmp && !rst) begin
      es   = exp_sel();
      cmdv = bus.cmd;
      chk("model_state", int'(bus.state), exp_state());
      chk("model_sel", int'(bus.sel), es);
      chk("model_holding", int'(bus.holding), int'(exp_state() == 2));
      chk("model_y", int'(bus.y), int'(cmdv[es*W +: W]));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int hc;

  initial begin
    checks  = 0;
    errors  = 0;
    run_cmp = 1'b0;
    rst     = 1'b1;
    bus.m   = 1'b0;
    bus.s   = '0;
    bus.cmd = '0;
    bus.cmd[1:0]   = 2'b10;
    bus.cmd[5:4]   = 2'b01;
    bus.cmd[11:10] = 2'b11;
    bus.cmd[17:16] = 2'b11;
    bus.cmd[31:30] = 2'b01;
    cyc(1);
    chk("rst_state", int'(bus.state), 0);
    chk("rst_y", int'(bus.y), 2);
    rst     = 1'b0;
    run_cmp = 1'b1;
    cyc(1);
    chk("idle_sel", int'(bus.sel), 0);

    // Priority and preemption
    bus.s = 16'h0004;
    #1 chk("pre_edge_sel", int'(bus.sel), 0);
    cyc(1);
    chk("prio_sel2", int'(bus.sel), 2);
    chk("prio_y01", int'(bus.y), 1);
    cyc(2);
    bus.s = 16'h0104;
    #1 chk("preempt_latency", int'(bus.sel), 2);
    cyc(1);
    chk("preempt_sel8", int'(bus.sel), 8);
    chk("preempt_y11", int'(bus.y), 3);
    bus.s = 16'h0004;
    cyc(1);
    chk("fallback_sel2", int'(bus.sel), 2);

    // Hold expiry
    bus.s = 16'h0020;
    cyc(1);
    chk("hold_track_sel5", int'(bus.sel), 5);
    bus.s = '0;
    hc = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (bus.holding) begin
        hc++;
        chk("hold_sel5", int'(bus.sel), 5);
      end
    end
    chk("hold_cycles", hc, 4);
    chk("hold_expired_state", int'(bus.state), 0);
    chk("hold_expired_sel", int'(bus.sel), 0);

    // Hold re-arm on the expiry cycle
    bus.s = 16'h0020;
    cyc(1);
    bus.s = '0;
    cyc(4);
    chk("rearm_holding", int'(bus.holding), 1);
    bus.s = 16'h0001;
    cyc(1);
    chk("rearm_state", int'(bus.state), 1);
    chk("rearm_sel", int'(bus.sel), 0);
    chk("rearm_holding0", int'(bus.holding), 0);

    // Override
    bus.s = 16'h8000;
    cyc(1);
    chk("ovr_pre_sel15", int'(bus.sel), 15);
    bus.cmd[1:0] = 2'b00;
    bus.m = 1'b1;
    cyc(1);
    chk("ovr_state", int'(bus.state), 3);
    chk("ovr_y", int'(bus.y), 0);
    bus.m = 1'b0;
    cyc(1);
    chk("ovr_exit_state", int'(bus.state), 1);
    chk("ovr_exit_sel", int'(bus.sel), 15);

    // Live command path
    bus.s = 16'h0010;
    cyc(1);
    for (int i = 0; i < 6; i++) begin
      bus.cmd[9:8] = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1 chk("live_y", int'(bus.y), (i % 2 == 0) ? 1 : 2);
      cyc(1);
    end

    // Mid-cycle reset while tracking
    bus.cmd[1:0] = 2'b10;
    #1 rst = 1'b1;
    #1;
    chk("midrst_state", int'(bus.state), 0);
    chk("midrst_sel", int'(bus.sel), 0);
    chk("midrst_y", int'(bus.y), 2);
    chk("midrst_holding", int'(bus.holding), 0);
    #2 rst = 1'b0;
    cyc(1);
    chk("post_rst_state", int'(bus.state), 1);
    chk("post_rst_sel", int'(bus.sel), 4);
    cyc(2);

    run_cmp = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
